// File: rtl/corelet_seq_if.sv
// Control/memory bus between the corelet sequencer and the corelet datapath:
// the in_ctrl word, the xmem read port, the pmem port and the datapath status flags.
interface corelet_seq_if #(
  parameter int unsigned xaddr_w = 11,
  parameter int unsigned paddr_w = 11
) ();
  logic [11:0]        in_ctrl;
  logic               xmem_cen;
  logic [xaddr_w-1:0] xmem_addr;
  logic               pmem_cen;
  logic               pmem_wen;
  logic [paddr_w-1:0] pmem_addr;
  logic               ofifo_valid;
  logic               l0_full;

  modport master (
    output in_ctrl, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
    input  ofifo_valid, l0_full
  );

  modport slave (
    input  in_ctrl, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr,
    output ofifo_valid, l0_full
  );
endinterface

// File: rtl/corelet_seq.sv
// Conv-pass sequencer for the corelet: per kij loads weights, streams activations,
// then folds each ofifo output row into pmem through the sfp, with optional ReLU on the last kij.
module corelet_seq #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned n_act   = 36,
  parameter int unsigned n_kij   = 9,
  parameter int unsigned xaddr_w = 11,
  parameter int unsigned paddr_w = 11,
  parameter int unsigned w_base  = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            relu_en,
  corelet_seq_if.master   bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned CNT_MAX = (row + col > n_act + 1) ? row + col : n_act + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned KIJ_W   = $clog2(n_kij + 1);
  localparam int unsigned O_W     = $clog2(n_act + 1);

  localparam logic [CNT_W-1:0] WWR_LAST  = CNT_W'(col);
  localparam logic [CNT_W-1:0] WLD_LAST  = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(row + col - 1);
  localparam logic [CNT_W-1:0] AWR_LAST  = CNT_W'(n_act);
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(n_act - 1);
  localparam logic [O_W-1:0]   O_LAST    = O_W'(n_act - 1);
  localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(n_kij - 1);

  localparam int unsigned B_L0_WR     = 2;
  localparam int unsigned B_L0_RD     = 3;
  localparam int unsigned B_OFIFO_RD  = 6;
  localparam int unsigned B_SFP_ACC   = 7;
  localparam int unsigned B_SFP_RELU  = 8;
  localparam int unsigned B_SFP_RESET = 10;
  localparam int unsigned B_SFP_SEL   = 11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_WR,
    S_W_LD,
    S_GAP,
    S_A_WR,
    S_EXEC,
    S_ACC_RST,
    S_ACC_PSUM,
    S_ACC_OF,
    S_ACC_RELU,
    S_ACC_WR,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [KIJ_W-1:0]   kij, kij_n;
  logic [O_W-1:0]     o, o_n;
  logic               relu_q;

  logic [11:0]        ctrl;
  logic               xcen;
  logic [xaddr_w-1:0] xaddr;
  logic               pcen;
  logic               pwen;
  logic [paddr_w-1:0] paddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kij    <= '0;
      o      <= '0;
      relu_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      kij   <= kij_n;
      o     <= o_n;
      if (state == S_IDLE && start) relu_q <= relu_en;
      if (ctrl[B_L0_WR] && bus.l0_full) err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    kij_n   = kij;
    o_n     = o;
    ctrl    = '0;
    xcen    = 1'b1;
    xaddr   = '0;
    pcen    = 1'b1;
    pwen    = 1'b1;
    paddr   = '0;
    busy    = 1'b1;
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        kij_n = '0;
        o_n   = '0;
        if (start) state_n = S_W_WR;
      end

      // Reads run on cycles 0..col-1; the L0 write trails by one cycle to
      // absorb the xmem read latency, hence the extra trailing cycle.
      S_W_WR: begin
        if (cnt != WWR_LAST) begin
          xcen  = 1'b0;
          xaddr = xaddr_w'(w_base + kij * col + cnt);
        end
        ctrl[B_L0_WR] = (cnt != '0);
        if (cnt == WWR_LAST) state_n = S_W_LD;
        else                 cnt_n   = cnt + 1'b1;
      end

      S_W_LD: begin
        ctrl[B_L0_RD] = 1'b1;
        ctrl[1:0]     = 2'b01;
        if (cnt == WLD_LAST) state_n = S_GAP;
        else                 cnt_n   = cnt + 1'b1;
      end

      S_GAP: begin
        if (cnt == GAP_LAST) state_n = S_A_WR;
        else                 cnt_n   = cnt + 1'b1;
      end

      S_A_WR: begin
        if (cnt != AWR_LAST) begin
          xcen  = 1'b0;
          xaddr = xaddr_w'(kij * n_act + cnt);
        end
        ctrl[B_L0_WR] = (cnt != '0);
        if (cnt == AWR_LAST) state_n = S_EXEC;
        else                 cnt_n   = cnt + 1'b1;
      end

      S_EXEC: begin
        ctrl[B_L0_RD] = 1'b1;
        ctrl[1:0]     = 2'b10;
        if (cnt == EXEC_LAST) state_n = S_ACC_RST;
        else                  cnt_n   = cnt + 1'b1;
      end

      S_ACC_RST: begin
        ctrl[B_SFP_RESET] = 1'b1;
        if (kij != '0) begin
          pcen    = 1'b0;
          paddr   = paddr_w'(o);
          state_n = S_ACC_PSUM;
        end else begin
          state_n = S_ACC_OF;
        end
      end

      S_ACC_PSUM: begin
        ctrl[B_SFP_SEL] = 1'b1;
        ctrl[B_SFP_ACC] = 1'b1;
        state_n         = S_ACC_OF;
      end

      // The only stalling step: ofifo_rd is gated by ofifo_valid in the same cycle.
      S_ACC_OF: begin
        if (bus.ofifo_valid) begin
          ctrl[B_OFIFO_RD] = 1'b1;
          ctrl[B_SFP_ACC]  = 1'b1;
          state_n = (kij == KIJ_LAST && relu_q) ? S_ACC_RELU : S_ACC_WR;
        end
      end

      S_ACC_RELU: begin
        ctrl[B_SFP_RELU] = 1'b1;
        state_n          = S_ACC_WR;
      end

      S_ACC_WR: begin
        pcen  = 1'b0;
        pwen  = 1'b0;
        paddr = paddr_w'(o);
        if (o == O_LAST) begin
          o_n = '0;
          if (kij == KIJ_LAST) begin
            state_n = S_DONE;
          end else begin
            kij_n   = kij + 1'b1;
            state_n = S_W_WR;
          end
        end else begin
          o_n     = o + 1'b1;
          state_n = S_ACC_RST;
        end
      end

      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        kij_n   = '0;
        state_n = S_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.in_ctrl   = ctrl;
  assign bus.xmem_cen  = xcen;
  assign bus.xmem_addr = xaddr;
  assign bus.pmem_cen  = pcen;
  assign bus.pmem_wen  = pwen;
  assign bus.pmem_addr = paddr;

endmodule

// File: tb/tb_corelet_seq.sv
// Randomized bench for corelet_seq: a per-cycle expectation script built from the pass
// rules is replayed against the DUT, with random ofifo stalls, l0_full, stray starts and a mid-pass reset.
module tb_corelet_seq;

  localparam int unsigned ROW   = 4;
  localparam int unsigned COL   = 8;
  localparam int unsigned NACT  = 4;
  localparam int unsigned NKIJ  = 3;
  localparam int unsigned XW    = 11;
  localparam int unsigned PW    = 11;
  localparam int unsigned WBASE = 1024;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic start   = 1'b0;
  logic relu_en = 1'b0;
  logic busy, done, err;

  corelet_seq_if #(.xaddr_w(XW), .paddr_w(PW)) bus ();

  corelet_seq #(
    .row(ROW), .col(COL), .n_act(NACT), .n_kij(NKIJ),
    .xaddr_w(XW), .paddr_w(PW), .w_base(WBASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]   ctrl;
    logic          xcen;
    logic [XW-1:0] xaddr;
    logic          pcen;
    logic          pwen;
    logic [PW-1:0] paddr;
    logic          busy;
    logic          done;
    bit            wait_v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  logic err_m    = 1'b0;
  int   hold_low = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic [11:0] ctrl, input logic xcen, input int unsigned xaddr,
                               input logic pcen, input logic pwen, input int unsigned paddr,
                               input logic b, input logic d, input bit wv);
    exp_t e;
    e.ctrl   = ctrl;
    e.xcen   = xcen;
    e.xaddr  = xaddr[XW-1:0];
    e.pcen   = pcen;
    e.pwen   = pwen;
    e.paddr  = paddr[PW-1:0];
    e.busy   = b;
    e.done   = d;
    e.wait_v = wv;
    exp_q.push_back(e);
  endfunction

  // One pass as a cycle-by-cycle script; the ofifo wait step is a single entry
  // that is held while ofifo_valid is low.
  function automatic void build_pass(input bit relu);
    for (int unsigned k = 0; k < NKIJ; k++) begin
      for (int unsigned i = 0; i <= COL; i++)
        push((i > 0) ? 12'h004 : 12'h000, (i < COL) ? 1'b0 : 1'b1,
             (i < COL) ? WBASE + k * COL + i : 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i < COL; i++)
        push(12'h009, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i < ROW + COL; i++)
        push(12'h000, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i <= NACT; i++)
        push((i > 0) ? 12'h004 : 12'h000, (i < NACT) ? 1'b0 : 1'b1,
             (i < NACT) ? k * NACT + i : 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      for (int unsigned i = 0; i < NACT; i++)
        push(12'h00A, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      for (int unsigned o = 0; o < NACT; o++) begin
        push(12'h400, 1'b1, 0, (k > 0) ? 1'b0 : 1'b1, 1'b1, (k > 0) ? o : 0, 1'b1, 1'b0, 1'b0);
        if (k > 0) push(12'h880, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        push(12'h0C0, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        if (k == NKIJ - 1 && relu) push(12'h100, 1'b1, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        push(12'h000, 1'b1, 0, 1'b0, 1'b0, o, 1'b1, 1'b0, 1'b0);
      end
    end
    push(12'h000, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic drive(input int l0f_pct);
    start   = ($urandom_range(0, 9) == 0);
    relu_en = 1'($urandom_range(0, 1));
    if (hold_low == 0 && $urandom_range(0, 15) == 0) hold_low = 20;
    if (hold_low > 0) begin
      bus.ofifo_valid = 1'b0;
      hold_low--;
    end else begin
      bus.ofifo_valid = ($urandom_range(0, 2) != 0);
    end
    bus.l0_full = ($urandom_range(0, 99) < l0f_pct);
  endtask

  task automatic compare_head();
    exp_t e = exp_q[0];
    logic [11:0] ce = e.ctrl;
    bit stalled = e.wait_v && !bus.ofifo_valid;
    if (stalled) ce = 12'h000;
    check("in_ctrl", 32'(bus.in_ctrl), 32'(ce));
    check("xmem", 32'({bus.xmem_cen, bus.xmem_addr}), 32'({e.xcen, e.xaddr}));
    check("pmem", 32'({bus.pmem_cen, bus.pmem_wen, bus.pmem_addr}), 32'({e.pcen, e.pwen, e.paddr}));
    check("busy_done", 32'({busy, done}), 32'({e.busy, e.done}));
    check("err", 32'(err), 32'(err_m));
    if (ce[2] && bus.l0_full) err_m = 1'b1;
    if (!stalled) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("rst_ctrl", 32'(bus.in_ctrl), 32'h0);
    check("rst_mem", 32'({bus.xmem_cen, bus.pmem_cen, bus.pmem_wen}), 32'h7);
    check("rst_addr", 32'({bus.xmem_addr, bus.pmem_addr}), 32'h0);
    check("rst_flags", 32'({busy, done, err}), 32'h0);
    err_m = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_pass(input bit relu, input int l0f_pct, input bit abort);
    int budget    = 0;
    int exec_seen = 0;
    bit aborted   = 1'b0;
    exp_q.delete();
    build_pass(relu);
    @(posedge clk);
    #1;
    start           = 1'b1;
    relu_en         = relu;
    bus.ofifo_valid = 1'b0;
    bus.l0_full     = 1'b0;
    @(negedge clk);
    check("idle_flags", 32'({busy, done}), 32'h0);
    check("idle_ctrl", 32'(bus.in_ctrl), 32'h0);
    while (exp_q.size() > 0 && budget < 20000 && !aborted) begin
      @(posedge clk);
      #1;
      drive(l0f_pct);
      @(negedge clk);
      if (exp_q[0].ctrl == 12'h00A) exec_seen++;
      compare_head();
      budget++;
      if (abort && exec_seen == NACT + 2) begin
        do_reset();
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check("pass_left", 32'(exp_q.size()), 32'h0);
      @(posedge clk);
      #1;
      start           = 1'b0;
      bus.ofifo_valid = 1'b0;
      @(negedge clk);
      check("post_idle", 32'({busy, done, bus.in_ctrl}), 32'h0);
    end
  endtask

  initial begin
    bus.ofifo_valid = 1'b0;
    bus.l0_full     = 1'b0;
    #12;
    check("init_ctrl", 32'(bus.in_ctrl), 32'h0);
    check("init_mem", 32'({bus.xmem_cen, bus.pmem_cen, bus.pmem_wen}), 32'h7);
    check("init_flags", 32'({busy, done, err}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_pass(1'b1, 0, 1'b0);
    run_pass(1'b0, 10, 1'b1);
    run_pass(1'b1, 5, 1'b0);
    run_pass(1'b0, 0, 1'b0);
    run_pass(1'b1, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
